// File: rtl/ram_defs.sv
`default_nettype none
// ============================================================================
// Module      : ram_defs (package)
// Description : Shared definitions for the RAM responder: transfer-size
//               encodings, FSM state encoding, default geometry and the
//               alignment predicate used when RAM_ALIGN_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_defs;

  // Transfer size encodings carried on dtype. 2'b11 is reserved and
  // handled exactly like a word everywhere.
  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_WORD = 2'b10;

  // Default geometry and timing.
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_WAIT_CYCLES = 2;

  // Wait-state counter width (covers 0..15).
  localparam int CNT_W = 4;

  // Responder FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_DONE    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // A halfword must sit on an even address; a word (or reserved size)
  // must sit on a multiple of four. Bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] dtype,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (dtype)
      DT_BYTE: mis = 1'b0;
      DT_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_byte_lane.sv
`default_nettype none
// ============================================================================
// Module      : ram_byte_lane
// Description : Combinational big-endian pack/unpack of 1, 2 or 4 bytes.
//               Lane k corresponds to the byte at address (a + k) and lives
//               in bits [31-8k -: 8] of rd_bytes / wr_bytes.
// Revision    : 1.0 - initial release
// Ports       :
//   dtype    in  2   transfer size (00 byte, 01 half, 10/11 word)
//   rd_bytes in  32  bytes at a, a+1, a+2, a+3 (lane 0 in bits 31:24)
//   wr_data  in  32  right-justified write data
//   rd_data  out 32  right-justified, zero-extended read data
//   wr_bytes out 32  write bytes placed in lane order
//   byte_en  out 4   bit k enables the write of lane k
// ============================================================================
module ram_byte_lane
  import ram_defs::*;
(
  input  logic [1:0]  dtype,
  input  logic [31:0] rd_bytes,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [31:0] wr_bytes,
  output logic [3:0]  byte_en
);

  always_comb begin
    rd_data  = rd_bytes;
    wr_bytes = wr_data;
    byte_en  = 4'b1111;
    case (dtype)
      DT_BYTE: begin
        rd_data  = {24'h000000, rd_bytes[31:24]};
        wr_bytes = {wr_data[7:0], 24'h000000};
        byte_en  = 4'b0001;
      end
      DT_HALF: begin
        rd_data  = {16'h0000, rd_bytes[31:16]};
        wr_bytes = {wr_data[15:0], 16'h0000};
        byte_en  = 4'b0011;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : ram_responder
// Description : Memory-side slave of the CPU MOV/MOC handshake. Byte
//               addressed, big-endian RAM serving byte/halfword/word reads
//               and writes after WAIT_CYCLES wait states. Addresses wrap
//               modulo DEPTH. The storage array is named Mem and is never
//               reset, so it can be preloaded hierarchically.
// Revision    : 1.0 - initial release
// Config      : RAM_ALIGN_CHECK_EN - when defined, misaligned halfword/word
//               accesses are suppressed, return dout=0 and raise fault with
//               moc. When undefined, fault is constant 0.
// Ports       :
//   clk   in  1       system clock, rising edge
//   clr   in  1       synchronous active-low reset
//   mov   in  1       memory operation valid (held until moc)
//   rw    in  1       1 = read, 0 = write
//   dtype in  2       transfer size
//   addr  in  ADDR_W  byte address of the most significant byte
//   din   in  32      right-justified write data
//   dout  out 32      right-justified, zero-extended read data
//   moc   out 1       one-cycle completion pulse
//   fault out 1       misalignment fault, valid with moc
// ============================================================================
module ram_responder
  import ram_defs::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              mov,
  input  logic              rw,
  input  logic [1:0]        dtype,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              moc,
  output logic              fault
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0] Mem [DEPTH];

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [1:0]          dtype_q, dtype_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         din_q, din_d;
  logic [31:0]         dout_q, dout_d;
  logic                moc_q, moc_d;
  logic                fault_q, fault_d;

  logic                access;
  logic                misaligned;
  logic                mem_we;
  logic [ADDR_W-1:0]   lane_addr [4];
  logic [31:0]         rd_bytes;
  logic [31:0]         rd_data;
  logic [31:0]         wr_bytes;
  logic [3:0]          byte_en;

  // The access edge is the BUSY cycle whose counter has run out.
  assign access = (state_q == ST_BUSY) && (cnt_q == '0);

  // Lane addresses wrap naturally through the ADDR_W-bit add.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = addr_q + ADDR_W'(k);
    end
  end

  assign rd_bytes = {Mem[lane_addr[0]], Mem[lane_addr[1]],
                     Mem[lane_addr[2]], Mem[lane_addr[3]]};

  ram_byte_lane u_lane (
    .dtype    (dtype_q),
    .rd_bytes (rd_bytes),
    .wr_data  (din_q),
    .rd_data  (rd_data),
    .wr_bytes (wr_bytes),
    .byte_en  (byte_en)
  );

`ifdef RAM_ALIGN_CHECK_EN
  assign misaligned = is_misaligned(dtype_q, addr_q[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // A reset landing on the access edge discards the pending write.
  assign mem_we = access && !rw_q && !misaligned && clr;

  // Storage has no reset so preloaded contents survive clr.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) begin
          Mem[lane_addr[k]] <= wr_bytes[31-8*k -: 8];
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      dtype_q <= DT_BYTE;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      moc_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      dtype_q <= dtype_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      moc_q   <= moc_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (mov)         state_d = ST_BUSY;
      ST_BUSY:    if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE:    state_d = mov ? ST_RELEASE : ST_IDLE;
      ST_RELEASE: if (!mov)        state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    dtype_d = dtype_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    moc_d   = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mov) begin
          rw_d    = rw;
          dtype_d = dtype;
          addr_d  = addr;
          din_d   = din;
          cnt_d   = CNT_W'(WAIT_CYCLES);
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          moc_d   = 1'b1;
          fault_d = misaligned;
          if (misaligned) begin
            dout_d = '0;
          end else if (rw_q) begin
            dout_d = rd_data;
          end
        end
      end
      default: ;
    endcase
  end

  assign dout  = dout_q;
  assign moc   = moc_q;
  assign fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_responder
// Description : Self-checking bench for ram_responder. Requests push their
//               expected dout/fault/completion cycle to a scoreboard which a
//               monitor pops on every moc pulse. A second instance with
//               WAIT_CYCLES=0 covers the minimum-latency case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_responder;

  localparam int W = 2;
`ifdef RAM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        mov = 1'b0, rw = 1'b0;
  logic [1:0]  dtype = 2'b00;
  logic [7:0]  addr = 8'h00;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic        moc, fault;

  logic        mov0 = 1'b0, rw0 = 1'b0;
  logic [1:0]  dtype0 = 2'b00;
  logic [7:0]  addr0 = 8'h00;
  logic [31:0] din0 = 32'h0;
  logic [31:0] dout0;
  logic        moc0, fault0;

  ram_responder #(.ADDR_W(8), .WAIT_CYCLES(W)) dut (
    .clk(clk), .clr(clr), .mov(mov), .rw(rw), .dtype(dtype), .addr(addr),
    .din(din), .dout(dout), .moc(moc), .fault(fault)
  );

  ram_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .clr(clr), .mov(mov0), .rw(rw0), .dtype(dtype0), .addr(addr0),
    .din(din0), .dout(dout0), .moc(moc0), .fault(fault0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] dout;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  model_mem [256];
  logic [31:0] last_dout = 32'h0;

  function automatic int nbytes(input logic [1:0] dt);
    if (dt == 2'b00) return 1;
    if (dt == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic is_mis(input logic [1:0] dt, input logic [7:0] a);
    return ALIGN_EN && ((dt == 2'b01 && a[0]) || (dt[1] && a[1:0] != 2'b00));
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] dt,
                                             input logic [7:0] a);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < nbytes(dt); i++) begin
      r = (r << 8) | {24'h0, model_mem[8'(a + i)]};
    end
    return r;
  endfunction

  task automatic model_write(input logic [1:0] dt, input logic [7:0] a,
                             input logic [31:0] d);
    int n;
    n = nbytes(dt);
    for (int i = 0; i < n; i++) begin
      model_mem[8'(a + i)] = d[8*(n-1-i) +: 8];
    end
  endtask

  // Every moc pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (moc === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("unexpected_moc", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("dout", dout, mon_e.dout);
        check_val("fault", {31'b0, fault}, {31'b0, mon_e.fault});
        check_val("moc_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Issue one request starting at a negedge with the DUT idle; returns at a
  // negedge with mov low and the DUT back in IDLE on the next edge.
  task automatic do_req(input logic r, input logic [1:0] dt,
                        input logic [7:0] a, input logic [31:0] d,
                        input int hold);
    exp_t e;
    bit   seen;
    if (is_mis(dt, a)) begin
      e.dout  = 32'h0;
      e.fault = 1'b1;
    end else if (r) begin
      e.dout  = model_read(dt, a);
      e.fault = 1'b0;
    end else begin
      model_write(dt, a, d);
      e.dout  = last_dout;
      e.fault = 1'b0;
    end
    last_dout = e.dout;
    mov = 1'b1; rw = r; dtype = dt; addr = a; din = d;
    @(posedge clk); #1;
    e.cyc = cyc + W + 1;
    sb.push_back(e);
    // Scramble inputs after acceptance; the latched copies must be used.
    rw = ~r; dtype = ~dt; addr = ~a; din = ~d;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (moc === 1'b1) seen = 1'b1;
    end
    if (!seen) check_val("moc_timeout", 32'd0, 32'd1);
    repeat (hold) @(negedge clk);
    mov = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dut.Mem[i]   = 8'h00;
      dut0.Mem[i]  = 8'h00;
      model_mem[i] = 8'h00;
    end
    dut.Mem[0] = 8'hE3; dut.Mem[1] = 8'hA0; dut.Mem[2] = 8'h10; dut.Mem[3] = 8'h04;
    model_mem[0] = 8'hE3; model_mem[1] = 8'hA0;
    model_mem[2] = 8'h10; model_mem[3] = 8'h04;
    dut0.Mem[5] = 8'h5A;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_dout", dout, 32'h0);
    check_val("rst_moc", {31'b0, moc}, 32'h0);
    check_val("rst_fault", {31'b0, fault}, 32'h0);
    clr = 1'b1;

    do_req(1'b1, 2'b10, 8'h00, 32'h0, 0);            // word read E3A01004
    do_req(1'b0, 2'b01, 8'h08, 32'h0000BEEF, 0);     // halfword write
    do_req(1'b1, 2'b00, 8'h08, 32'h0, 0);            // byte read BE
    do_req(1'b1, 2'b00, 8'h09, 32'h0, 0);            // byte read EF
    do_req(1'b1, 2'b01, 8'h08, 32'h0, 10);           // held mov, one moc only
    do_req(1'b1, 2'b00, 8'h02, 32'h0, 0);            // re-armed after drop
    do_req(1'b0, 2'b10, 8'hFE, 32'h11223344, 0);     // wrap / misaligned word
    for (int i = 0; i < 4; i++) begin
      check_val("wrap_mem", {24'h0, dut.Mem[8'(254 + i)]},
                {24'h0, model_mem[8'(254 + i)]});
    end
    do_req(1'b1, 2'b10, 8'hFE, 32'h0, 0);            // read back across wrap
    do_req(1'b1, 2'b11, 8'h00, 32'h0, 0);            // reserved size as word

    // Reset while a write to address 4 is waiting in BUSY.
    mov = 1'b1; rw = 1'b0; dtype = 2'b00; addr = 8'h04; din = 32'h000000A5;
    @(posedge clk); #1;
    @(negedge clk);
    clr = 1'b0; mov = 1'b0;
    @(negedge clk);
    check_val("abort_dout", dout, 32'h0);
    check_val("abort_moc", {31'b0, moc}, 32'h0);
    check_val("abort_fault", {31'b0, fault}, 32'h0);
    last_dout = 32'h0;
    clr = 1'b1;
    repeat (6) @(negedge clk);
    check_val("abort_mem4", {24'h0, dut.Mem[4]}, {24'h0, model_mem[4]});
    do_req(1'b1, 2'b00, 8'h03, 32'h0, 0);            // normal after abort

    // Zero wait states: moc during the cycle after edge E0+1.
    mov0 = 1'b1; rw0 = 1'b1; dtype0 = 2'b00; addr0 = 8'h05;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("w0_early_moc", {31'b0, moc0}, 32'h0);
    @(negedge clk);
    check_val("w0_moc", {31'b0, moc0}, 32'h1);
    check_val("w0_dout", dout0, 32'h0000005A);
    mov0 = 1'b0;
    @(negedge clk);
    check_val("w0_moc_pulse", {31'b0, moc0}, 32'h0);

    repeat (3) @(negedge clk);
    check_val("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
